// File: rtl/mem_sync.sv
// mem_sync: row-cache tag controller for the memory emulator.
//
// Keeps a fully associative tag table of 2**CHWIDTH slots. Each slot maps an
// open DRAM row (RowId) onto a cache slot index (cRowId). The controller
// decodes ACT/RD/WR/PR host commands and allocates a slot on a miss. When the
// victim slot holds dirty data, it first sequences a write-back. Every
// write-back and allocation transfer completes on a one-cycle `sync` pulse
// from the data mover. `stall` is high while the controller is busy.
//
// Ports:
//   clk     in   1          system clock, rising edge
//   rst     in   1          synchronous active-high reset
//   ACT     in   1          activate; row address on RowId
//   RD      in   1          read burst to the open row (level)
//   WR      in   1          write burst to the open row (level)
//   PR      in   1          precharge, closes the open row
//   RowId   in   ADDRWIDTH  row address, sampled with ACT
//   sync    in   1          current WriteBack/Allocate transfer is complete
//   cRowId  out  CHWIDTH    slot of the open (or allocating) row
//   stall   out  1          controller busy, host must hold off commands
module mem_sync #(
  parameter int CHWIDTH   = 6,
  parameter int ADDRWIDTH = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ACT,
  input  logic                 RD,
  input  logic                 WR,
  input  logic                 PR,
  input  logic [ADDRWIDTH-1:0] RowId,
  input  logic                 sync,
  output logic [CHWIDTH-1:0]   cRowId,
  output logic                 stall
);

  localparam int NSLOTS = 1 << CHWIDTH;

  typedef enum logic [2:0] {
    Idle       = 3'd0,
    Activate   = 3'd1,
    CompareTag = 3'd2,
    Allocate   = 3'd3,
    WriteBack  = 3'd4,
    hitRD      = 3'd5,
    hitWR      = 3'd6
  } stateType;

  stateType state;
  stateType nextState;

  logic [ADDRWIDTH-1:0] tag [NSLOTS];
  logic [NSLOTS-1:0]    valid;
  logic [NSLOTS-1:0]    dirty;
  logic [CHWIDTH-1:0]   ptr;
  logic [ADDRWIDTH-1:0] rowReg;

  logic [NSLOTS-1:0]    matchVec;
  logic                 hit;
  logic [CHWIDTH-1:0]   hitIdx;
  logic                 victimDirty;
  logic                 stallNext;

  // Parallel tag lookup. Duplicate tags cannot exist, so at most one bit of
  // matchVec is set. The downward scan still picks the lowest index, which
  // keeps the encoder well defined.
  always_comb begin
    matchVec = '0;
    hitIdx   = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (valid[i] && (tag[i] == rowReg)) begin
        matchVec[i] = 1'b1;
        hitIdx      = CHWIDTH'(i);
      end
    end
  end

  assign hit         = |matchVec;
  assign victimDirty = valid[ptr] & dirty[ptr];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= Idle;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. Inputs that a state does not list are ignored. This
  // includes sync outside WriteBack/Allocate, which is dropped rather than
  // remembered.
  always_comb begin
    nextState = state;
    case (state)
      Idle: begin
        if (ACT) nextState = Activate;
      end
      Activate: begin
        if (hit)              nextState = CompareTag;
        else if (victimDirty) nextState = WriteBack;
        else                  nextState = Allocate;
      end
      WriteBack: begin
        if (sync) nextState = Allocate;
      end
      Allocate: begin
        if (sync) nextState = CompareTag;
      end
      CompareTag: begin
        if (WR)      nextState = hitWR;
        else if (RD) nextState = hitRD;
        else if (PR) nextState = Idle;
      end
      hitWR: begin
        if (!WR) nextState = CompareTag;
      end
      hitRD: begin
        if (!RD) nextState = CompareTag;
      end
      default: nextState = Idle;
    endcase
  end

  // Output decode. stall is registered from the next state, so the
  // registered value tracks the busy states exactly and never glitches.
  always_comb begin
    stallNext = 1'b0;
    case (nextState)
      Activate, WriteBack, Allocate: stallNext = 1'b1;
      default:                       stallNext = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall <= 1'b0;
    end else begin
      stall <= stallNext;
    end
  end

  // Slot bookkeeping: row latch, cache slot output, valid/dirty flags and
  // the round-robin victim pointer. Reset has priority, so a transfer that
  // is aborted mid-way never marks a slot valid and never moves ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      rowReg <= '0;
      cRowId <= '0;
      valid  <= '0;
      dirty  <= '0;
      ptr    <= '0;
    end else begin
      case (state)
        Idle: begin
          if (ACT) rowReg <= RowId;
        end
        Activate: begin
          cRowId <= hit ? hitIdx : ptr;
        end
        WriteBack: begin
          if (sync) dirty[ptr] <= 1'b0;
        end
        Allocate: begin
          if (sync) begin
            valid[ptr] <= 1'b1;
            dirty[ptr] <= 1'b0;
            ptr        <= ptr + CHWIDTH'(1);
          end
        end
        hitWR: begin
          dirty[cRowId] <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Tag storage has no reset because its contents are qualified by valid.
  // The write is still gated by rst so that an aborted allocation leaves
  // the old tag in place.
  always_ff @(posedge clk) begin
    if (!rst && (state == Allocate) && sync) begin
      tag[ptr] <= rowReg;
    end
  end

endmodule

// File: tb/tb_mem_sync.sv
// tb_mem_sync: directed testbench for mem_sync.
//
// Inputs are driven and outputs sampled on the falling clock edge. The bench
// steps through open/write/read/precharge on a single row, a full table
// fill, dirty round-robin eviction, hits, and the boundary cases (RD+WR
// priority, stray sync in Idle, reset during Allocate).
module tb_mem_sync;

  localparam int CHWIDTH   = 6;
  localparam int ADDRWIDTH = 17;
  localparam int NSLOTS    = 1 << CHWIDTH;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 ACT = 1'b0;
  logic                 RD = 1'b0;
  logic                 WR = 1'b0;
  logic                 PR = 1'b0;
  logic                 sync = 1'b0;
  logic [ADDRWIDTH-1:0] RowId = '0;
  logic [CHWIDTH-1:0]   cRowId;
  logic                 stall;

  int checkCount = 0;
  int errorCount = 0;

  logic [ADDRWIDTH-1:0] row;

  always #5 clk = ~clk;

  mem_sync #(
    .CHWIDTH  (CHWIDTH),
    .ADDRWIDTH(ADDRWIDTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ACT   (ACT),
    .RD    (RD),
    .WR    (WR),
    .PR    (PR),
    .RowId (RowId),
    .sync  (sync),
    .cRowId(cRowId),
    .stall (stall)
  );

  // Compare one observed value with its expected value and log a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  // Drive all inputs for one clock cycle. Returns at the following falling
  // edge, with the rising-edge results settled and ready to sample.
  task automatic applyStimulus(input logic r, input logic act, input logic rd,
                               input logic wr, input logic pr, input logic snc,
                               input logic [ADDRWIDTH-1:0] rowIn);
    rst   = r;
    ACT   = act;
    RD    = rd;
    WR    = wr;
    PR    = pr;
    sync  = snc;
    RowId = rowIn;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, 0, 0, '0);
    checkOutput("reset state", 64'(dut.state), 64'd0);
    checkOutput("reset stall", 64'(stall), 64'd0);
    checkOutput("reset cRowId", 64'(cRowId), 64'd0);
    checkOutput("reset ptr", 64'(dut.ptr), 64'd0);
    checkOutput("reset valid", 64'(dut.valid), 64'd0);

    // First ACT: clean miss into slot 0
    row = 17'h01234;
    applyStimulus(0, 1, 0, 0, 0, 0, row);
    checkOutput("act state", 64'(dut.state), 64'd1);
    checkOutput("act stall", 64'(stall), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, '0);
    checkOutput("alloc state", 64'(dut.state), 64'd3);
    checkOutput("alloc stall", 64'(stall), 64'd1);
    checkOutput("alloc cRowId", 64'(cRowId), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, '0);
    checkOutput("open state", 64'(dut.state), 64'd2);
    checkOutput("open stall", 64'(stall), 64'd0);
    checkOutput("open tag0", 64'(dut.tag[0]), 64'h1234);
    checkOutput("open ptr", 64'(dut.ptr), 64'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, '0);
      checkOutput("open hold", 64'(dut.state), 64'd2);
    end

    // Write, write again, read, precharge
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0, '0);
    checkOutput("wr state", 64'(dut.state), 64'd6);
    checkOutput("wr dirty0", 64'(dut.dirty[0]), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, '0);
    checkOutput("wr release", 64'(dut.state), 64'd2);
    applyStimulus(0, 0, 0, 1, 0, 0, '0);
    checkOutput("wr again", 64'(dut.state), 64'd6);
    applyStimulus(0, 0, 0, 0, 0, 0, '0);
    checkOutput("wr again release", 64'(dut.state), 64'd2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, '0);
    checkOutput("rd state", 64'(dut.state), 64'd5);
    applyStimulus(0, 0, 0, 0, 0, 0, '0);
    checkOutput("rd release", 64'(dut.state), 64'd2);
    applyStimulus(0, 0, 0, 0, 1, 0, '0);
    checkOutput("pr state", 64'(dut.state), 64'd0);

    // Fill the whole table from a fresh reset; every row gets written
    applyStimulus(1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < NSLOTS; i++) begin
      row = ADDRWIDTH'(32'h100 + i);
      applyStimulus(0, 1, 0, 0, 0, 0, row);
      checkOutput("fill act", 64'(dut.state), 64'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, '0);
      checkOutput("fill alloc", 64'(dut.state), 64'd3);
      checkOutput("fill slot", 64'(cRowId), 64'(i));
      applyStimulus(0, 0, 0, 0, 0, 1, '0);
      checkOutput("fill open", 64'(dut.state), 64'd2);
      applyStimulus(0, 0, 0, 1, 0, 0, '0);
      applyStimulus(0, 0, 0, 0, 0, 0, '0);
      applyStimulus(0, 0, 0, 0, 1, 0, '0);
      checkOutput("fill closed", 64'(dut.state), 64'd0);
    end
    checkOutput("fill ptr wrap", 64'(dut.ptr), 64'd0);
    checkOutput("fill valid", 64'(dut.valid), {64{1'b1}});
    checkOutput("fill dirty", 64'(dut.dirty), {64{1'b1}});

    // Dirty eviction of slots 0..15
    for (int j = 0; j < 16; j++) begin
      row = ADDRWIDTH'(32'h2000 + j);
      applyStimulus(0, 1, 0, 0, 0, 0, row);
      applyStimulus(0, 0, 0, 0, 0, 0, '0);
      checkOutput("evict wb", 64'(dut.state), 64'd4);
      checkOutput("evict slot", 64'(cRowId), 64'(j));
      applyStimulus(0, 0, 0, 0, 0, 0, '0);
      checkOutput("evict wb wait", 64'(dut.state), 64'd4);
      checkOutput("evict wb stall", 64'(stall), 64'd1);
      applyStimulus(0, 0, 0, 0, 0, 1, '0);
      checkOutput("evict alloc", 64'(dut.state), 64'd3);
      checkOutput("evict clean", 64'(dut.dirty[j]), 64'd0);
      applyStimulus(0, 0, 0, 0, 0, 1, '0);
      checkOutput("evict open", 64'(dut.state), 64'd2);
      checkOutput("evict tag", 64'(dut.tag[j]), 64'(row));
      checkOutput("evict ptr", 64'(dut.ptr), 64'(j + 1));
      applyStimulus(0, 0, 0, 0, 1, 0, '0);
    end

    // Hit on an untouched slot, then RD+WR together
    applyStimulus(0, 1, 0, 0, 0, 0, 17'h00114);
    checkOutput("hit act", 64'(dut.state), 64'd1);
    checkOutput("hit act stall", 64'(stall), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, '0);
    checkOutput("hit open", 64'(dut.state), 64'd2);
    checkOutput("hit slot", 64'(cRowId), 64'd20);
    checkOutput("hit stall", 64'(stall), 64'd0);
    checkOutput("hit ptr", 64'(dut.ptr), 64'd16);
    applyStimulus(0, 0, 1, 1, 0, 0, '0);
    checkOutput("rd+wr prio", 64'(dut.state), 64'd6);
    applyStimulus(0, 0, 0, 0, 0, 0, '0);
    checkOutput("rd+wr release", 64'(dut.state), 64'd2);
    applyStimulus(0, 0, 0, 0, 1, 0, '0);

    // Hit on a slot that was refilled by eviction
    applyStimulus(0, 1, 0, 0, 0, 0, 17'h02005);
    applyStimulus(0, 0, 0, 0, 0, 0, '0);
    checkOutput("hit2 open", 64'(dut.state), 64'd2);
    checkOutput("hit2 slot", 64'(cRowId), 64'd5);
    applyStimulus(0, 0, 0, 0, 1, 0, '0);

    // Stray sync in Idle is dropped
    applyStimulus(0, 0, 0, 0, 0, 1, '0);
    checkOutput("idle sync state", 64'(dut.state), 64'd0);
    checkOutput("idle sync ptr", 64'(dut.ptr), 64'd16);
    checkOutput("idle sync stall", 64'(stall), 64'd0);

    // Reset during Allocate aborts the transfer
    applyStimulus(1, 0, 0, 0, 0, 0, '0);
    applyStimulus(0, 1, 0, 0, 0, 0, 17'h03000);
    applyStimulus(0, 0, 0, 0, 0, 0, '0);
    checkOutput("abort alloc", 64'(dut.state), 64'd3);
    applyStimulus(1, 0, 0, 0, 0, 1, '0);
    checkOutput("abort state", 64'(dut.state), 64'd0);
    checkOutput("abort valid", 64'(dut.valid), 64'd0);
    checkOutput("abort ptr", 64'(dut.ptr), 64'd0);
    checkOutput("abort stall", 64'(stall), 64'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 17'h03000);
    applyStimulus(0, 0, 0, 0, 0, 0, '0);
    checkOutput("abort remiss", 64'(dut.state), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
